uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Two-requester scheduler in front of the UART transmitter. It shares the single TX serialiser between two byte sources, for example the 8051 SBUF write path and the debug monitor. It arbitrates between them, drives the transmitter's edge-sensitive enable with the correct pulse shape, holds the byte stable while the transmitter samples it, and waits for transmit completion. A watchdog recovers if the transmitter never reports completion.

## Interface
Parameters:
- CLKS_PER_BIT, 868: must match the transmitter's setting; used only to size the watchdog.
- TIMEOUT_CLKS, 11*CLKS_PER_BIT+16: cycles allowed in WAIT before the transfer is abandoned.

Ports:
- i_clk, in, 1: system clock.
- i_rst, in, 1: reset. One clock; reset is synchronous and active-high.
- i_req0_valid, in, 1: requester 0 has a byte.
- i_req0_data, in, 8: requester 0 byte.
- o_req0_ready, out, 1: requester 0 byte accepted this cycle.
- i_req1_valid, in, 1: requester 1 has a byte.
- i_req1_data, in, 8: requester 1 byte.
- o_req1_ready, out, 1: requester 1 byte accepted this cycle.
- o_tx_byte, out, 8: to transmitter i_byte.
- o_tx_en, out, 1: to transmitter i_tx_en.
- i_tx_complete, in, 1: from transmitter o_complete.
- o_done, out, 2: one-cycle pulse, bit N = requester N's byte fully sent.
- o_timeout, out, 1: one-cycle pulse, watchdog expired.
- o_busy, out, 1: high in every state except IDLE.
- o_owner, out, 1: index of the requester currently being served; valid while o_busy.

## Operation
- States: IDLE → LOAD1 → LOAD2 → WAIT → IDLE.
- IDLE:
  - o_reqN_ready is combinational: IDLE & arbiter grant N.
  - At most one ready is asserted per cycle.
  - A transfer occurs when valid & ready. On transfer, data is latched into o_tx_byte, o_owner is set to N, and the state goes to LOAD1.
- Arbitration:
  - Only one valid asserted: that requester is granted.
  - Both valid: round-robin. The requester not served last wins.
  - The pointer resets to "1 served last", so requester 0 wins the first tie.
- LOAD1 and LOAD2: o_tx_en = 1, o_tx_byte held. The transmitter sees the rising edge one cycle later and latches the byte while it is still held.
- WAIT:
  - o_tx_en = 0 and o_tx_byte is held.
  - The watchdog counter counts from 0.
  - On i_tx_complete: o_done[o_owner] pulses, the round-robin pointer updates to o_owner, and the state goes to IDLE.
  - If the counter reaches TIMEOUT_CLKS − 1 with no complete: o_timeout pulses, o_done stays 0, the pointer still updates, and the state goes to IDLE.
- i_tx_complete outside WAIT is ignored.
- Requester data is sampled only on the transfer cycle. A requester may change data or deassert valid at any time before ready; no ordering is promised across requesters.
- Arithmetic: the watchdog counter is 16 bits and saturates at its limit. The TIMEOUT_CLKS default at CLKS_PER_BIT=868 is 9564, which fits.

## Timing
- Reset: all outputs 0. State IDLE, o_tx_byte = 0, counter = 0, pointer = 1.
- Reset mid-transfer: abandon immediately, with no o_done or o_timeout pulse. The transmitter shares i_rst and resets with the scheduler.
- Acceptance latency: ready is asserted in the same cycle as valid when idle and granted.
- o_tx_en rises the cycle after transfer and is high for exactly 2 cycles.
- o_tx_en is always low for more than 1 cycle between pulses. WAIT lasts far longer than 1 cycle, which guarantees a fresh rising edge each time.
- Completion: the cycle after i_tx_complete = 1 is IDLE with o_done pulsed. A new transfer may be accepted in that same IDLE cycle. The transmitter has already returned to idle by the next LOAD1.
- Back-to-back throughput: 1 frame + 4 cycles per byte.
- Simultaneous i_tx_complete and watchdog expiry in the same cycle: complete wins. o_done pulses and o_timeout does not.

## Configuration
- UART_TX_SCHED_PRIO_EN defined: fixed priority. Requester 0 always wins ties and the round-robin pointer is unused.
- Undefined: round-robin as described under Operation.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, LOAD1, LOAD2, WAIT);
  - the TX_FRAME_BITS = 10 constant;
  - the watchdog width constant.
- One natural sub-module, uart_rr_arb2. Inputs: 2 requests and the last-served pointer. Output: one-hot grant. The priority macro takes effect inside it.

## Test plan
- Single request: req0 with 0xA5 → ready for 1 cycle, o_tx_en high for exactly 2 cycles, serial line shows 0xA5 LSB-first, o_done = 01 the cycle after complete.
- Tie: both valid from reset with 0x11 and 0x22 held → order 0x11, 0x22, 0x11, 0x22 with round-robin. With UART_TX_SCHED_PRIO_EN, 0x11 repeats while req0 stays valid.
- Back-to-back: req1 streams 0x00..0x03 → four frames, each o_tx_en pulse preceded by a low cycle, o_done = 10 four times.
- Watchdog: i_tx_complete tied 0 after acceptance → o_timeout pulses at WAIT cycle TIMEOUT_CLKS − 1, state returns to IDLE, no o_done.
- Reset in WAIT: assert i_rst during WAIT → next cycle all outputs 0, no pulses, and a following req0 is accepted normally.
- Data change: req0 alters i_req0_data after acceptance → the transmitted byte equals the value at the acceptance cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the scheduler state encoding, frame length and watchdog width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD1 = 2'd1,
    LOAD2 = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int TX_FRAME_BITS = 10;
  localparam int WDOG_W        = 16;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way arbiter: a lone request wins, ties go to the requester not served last.
// Optional macro UART_TX_SCHED_PRIO_EN switches ties to fixed priority (requester 0).
module uart_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
`ifdef UART_TX_SCHED_PRIO_EN
      grant = 2'b01;
`else
      // last == 1 means requester 1 was served last, so requester 0 goes now
      grant = last ? 2'b01 : 2'b10;
`endif
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART serialiser between two byte sources, shaping the TX enable pulse
// and guarding each transfer with a watchdog. Macro: UART_TX_SCHED_PRIO_EN (fixed priority).
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 11 * CLKS_PER_BIT + 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  output logic       o_req1_ready,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_en,
  input  logic       i_tx_complete,
  output logic [1:0] o_done,
  output logic       o_timeout,
  output logic       o_busy,
  output logic       o_owner
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CLKS - 1);

  state_t            state_reg, state_next;
  logic [7:0]        byte_reg, byte_next;
  logic              owner_reg, owner_next;
  logic              last_reg, last_next;
  logic [WDOG_W-1:0] cnt_reg, cnt_next;
  logic [1:0]        done_reg, done_next;
  logic              timeout_reg, timeout_next;

  logic [1:0] req;
  logic [1:0] grant;
  logic [1:0] xfer;
  logic [1:0] owner_hot;
  logic       idle;

  assign req  = {i_req1_valid, i_req0_valid};
  assign idle = (state_reg == IDLE);

  uart_rr_arb2 u_arb (
    .req   (req),
    .last  (last_reg),
    .grant (grant)
  );

  // Readies are gated by reset so no handshake is reported while it cannot complete
  assign o_req0_ready = idle & grant[0] & ~i_rst;
  assign o_req1_ready = idle & grant[1] & ~i_rst;
  assign xfer         = req & {o_req1_ready, o_req0_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_owner_hot
      assign owner_hot[gi] = (owner_reg == 1'(gi));
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    byte_next    = byte_reg;
    owner_next   = owner_reg;
    last_next    = last_reg;
    cnt_next     = cnt_reg;
    done_next    = 2'b00;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (xfer != 2'b00) begin
          byte_next  = xfer[1] ? i_req1_data : i_req0_data;
          owner_next = xfer[1];
          state_next = LOAD1;
        end
      end
      LOAD1: state_next = LOAD2;
      LOAD2: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // Completion takes precedence over a watchdog expiry in the same cycle
        if (i_tx_complete) begin
          done_next  = owner_hot;
          last_next  = owner_reg;
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg == WDOG_LAST) begin
          timeout_next = 1'b1;
          last_next    = owner_reg;
          cnt_next     = '0;
          state_next   = IDLE;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + WDOG_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      byte_reg    <= 8'h00;
      owner_reg   <= 1'b0;
      last_reg    <= 1'b1;
      cnt_reg     <= '0;
      done_reg    <= 2'b00;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      byte_reg    <= byte_next;
      owner_reg   <= owner_next;
      last_reg    <= last_next;
      cnt_reg     <= cnt_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
    end
  end

  assign o_tx_byte = byte_reg;
  assign o_tx_en   = (state_reg == LOAD1) || (state_reg == LOAD2);
  assign o_busy    = ~idle;
  assign o_owner   = owner_reg;
  assign o_done    = done_reg;
  assign o_timeout = timeout_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: cycle model of the scheduler rules,
// a behavioural UART transmitter/receiver pair and directed scenarios.
module tb_uart_tx_sched;

  localparam int CPB = 4;
  localparam int T   = 11 * CPB + 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_byte;
  logic       tx_en;
  logic       tx_complete = 1'b0;
  logic [1:0] done;
  logic       timeout;
  logic       busy;
  logic       owner;

  always #5 clk = ~clk;

  uart_tx_sched #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req0_valid  (req0_valid),
    .i_req0_data   (req0_data),
    .o_req0_ready  (req0_ready),
    .i_req1_valid  (req1_valid),
    .i_req1_data   (req1_data),
    .o_req1_ready  (req1_ready),
    .o_tx_byte     (tx_byte),
    .o_tx_en       (tx_en),
    .i_tx_complete (tx_complete),
    .o_done        (done),
    .o_timeout     (timeout),
    .o_busy        (busy),
    .o_owner       (owner)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
  endtask

  // Behavioural transmitter: starts on a rising enable, sends a 10-bit frame
  logic       serial = 1'b1;
  bit         tx_mute = 1'b0;
  bit         tx_act = 1'b0;
  int         tx_cnt = 0;
  logic [9:0] tx_sh = '0;
  logic       prev_en = 1'b0;

  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      tx_act = 0; tx_complete = 1'b0; serial = 1'b1; prev_en = 1'b0;
    end else begin
      tx_complete = 1'b0;
      if (tx_act) begin
        tx_cnt++;
        if (tx_cnt == 10 * CPB) begin
          tx_act = 0;
          tx_complete = !tx_mute;
        end
      end else if (tx_en && !prev_en) begin
        tx_sh  = {1'b1, tx_byte, 1'b0};
        tx_cnt = 0;
        tx_act = 1;
      end
      serial  = tx_act ? tx_sh[tx_cnt / CPB] : 1'b1;
      prev_en = tx_en;
    end
  end

  // Receiver decodes the serial line at bit centres
  logic [7:0] rx_q[$];
  bit         rx_act = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (serial == 1'b0) begin rx_act = 1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_sh[rx_cnt / CPB - 1] = serial;
        else if (rx_cnt / CPB == 9) begin rx_q.push_back(rx_sh); rx_act = 0; end
      end
    end
  end

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_q.size()) return {24'h0, rx_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  // Scheduler model: phase k counts cycles since acceptance (1 = first enable cycle)
  bit         chk_en = 0;
  int         cyc = 0;
  bit         m_busy = 0;
  int         m_k = 0;
  logic       m_owner = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       m_last = 1'b1;
  logic [1:0] m_done = 2'b00;
  logic       m_to = 1'b0;

  int rdy0_cnt = 0, rdy1_cnt = 0, done0_cnt = 0, done1_cnt = 0, to_cnt = 0;
  int en_run = 0, last_en_run = 0, low_run = 0, min_low = 1000;
  int accept_cyc = 0, to_cyc = 0;
  bit seen_en = 0;
  logic [1:0] last_done = 2'b00;

  initial forever begin
    int w;
    logic [15:0] e, a;
    @(negedge clk);
    #2;
    cyc++;
    w = -1;
    if (!m_busy && !rst) begin
      if (req0_valid && req1_valid) begin
`ifdef UART_TX_SCHED_PRIO_EN
        w = 0;
`else
        w = m_last ? 0 : 1;
`endif
      end else if (req0_valid) w = 0;
      else if (req1_valid) w = 1;
    end
    e = {w == 1, w == 0, m_busy && (m_k == 1 || m_k == 2), m_busy, m_owner, m_done, m_to, m_byte};
    a = {req1_ready, req0_ready, tx_en, busy, owner, done, timeout, tx_byte};
    if (chk_en) chk("cycle_outputs", a, e);

    if (req0_ready && req0_valid) begin rdy0_cnt++; accept_cyc = cyc; end
    if (req1_ready && req1_valid) begin rdy1_cnt++; accept_cyc = cyc; end
    if (tx_en) begin
      if (en_run == 0 && seen_en && low_run < min_low) min_low = low_run;
      en_run++; low_run = 0; seen_en = 1;
    end else begin
      if (en_run > 0) last_en_run = en_run;
      en_run = 0; low_run++;
    end
    if (done[0]) done0_cnt++;
    if (done[1]) done1_cnt++;
    if (done != 2'b00) last_done = done;
    if (timeout) begin to_cnt++; to_cyc = cyc; end

    if (rst) begin
      m_busy = 0; m_k = 0; m_owner = 1'b0; m_byte = 8'h00;
      m_last = 1'b1; m_done = 2'b00; m_to = 1'b0;
    end else begin
      m_done = 2'b00; m_to = 1'b0;
      if (!m_busy) begin
        if (w >= 0) begin
          m_busy = 1; m_k = 1; m_owner = (w == 1);
          m_byte = (w == 1) ? req1_data : req0_data;
        end
      end else if (m_k >= 3) begin
        if (tx_complete) begin
          m_busy = 0; m_done = m_owner ? 2'b10 : 2'b01; m_last = m_owner;
        end else if (m_k - 3 == T - 1) begin
          m_busy = 0; m_to = 1'b1; m_last = m_owner;
        end else m_k++;
      end else m_k++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    tick(1);
    rst = 1'b0;
    rx_q.delete();
    seen_en = 0; min_low = 1000;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done0_cnt + done1_cnt < target && n < 500) begin tick(1); n++; end
    if (n >= 500) bound_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || tx_act || rx_act) && n < 500) begin tick(1); n++; end
    if (n >= 500) bound_fail(name);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int b0, b1, bd, bt, n;
    logic [7:0] tie_exp [4];
    tick(2);
    rst = 1'b0;
    chk_en = 1;
    #3;
    chk("reset_outputs", {tx_byte, tx_en, busy, owner, done, timeout, req0_ready, req1_ready}, 32'h0);

    // Single request from requester 0
    tick(1);
    b0 = rdy0_cnt; bd = done0_cnt + done1_cnt;
    req0_data = 8'hA5; req0_valid = 1'b1;
    tick(1);
    req0_valid = 1'b0; req0_data = 8'h00;
    wait_done(bd + 1, "t1_wait_done");
    wait_idle("t1_wait_idle");
    chk("t1_ready_cycles", rdy0_cnt - b0, 1);
    chk("t1_txen_width", last_en_run, 2);
    chk("t1_done_value", last_done, 2'b01);
    chk("t1_rx_byte", rx_at(0), 32'hA5);

    // Tie with both requesters held valid
    do_reset();
    bd = done0_cnt + done1_cnt;
    req0_data = 8'h11; req1_data = 8'h22;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_done(bd + 4, "t2_wait_done");
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("t2_wait_idle");
`ifdef UART_TX_SCHED_PRIO_EN
    tie_exp = '{8'h11, 8'h11, 8'h11, 8'h11};
`else
    tie_exp = '{8'h11, 8'h22, 8'h11, 8'h22};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("t2_tie_byte%0d", i), rx_at(i), {24'h0, tie_exp[i]});

    // Back-to-back stream from requester 1
    do_reset();
    b0 = done0_cnt; b1 = done1_cnt;
    for (int i = 0; i < 4; i++) begin
      req1_data = 8'(i); req1_valid = 1'b1;
      n = 0;
      #1;
      while (!req1_ready && n < 500) begin tick(1); #1; n++; end
      if (n >= 500) bound_fail("t3_wait_ready");
      tick(1);
    end
    req1_valid = 1'b0;
    wait_done(b0 + b1 + 4, "t3_wait_done");
    wait_idle("t3_wait_idle");
    for (int i = 0; i < 4; i++) chk($sformatf("t3_stream_byte%0d", i), rx_at(i), i);
    chk("t3_done1_count", done1_cnt - b1, 4);
    chk("t3_done0_count", done0_cnt - b0, 0);
    chk("t3_en_low_gap_gt1", min_low > 1, 1);

    // Watchdog: transmitter never reports completion
    do_reset();
    tx_mute = 1'b1;
    bd = done0_cnt + done1_cnt; bt = to_cnt;
    req0_data = 8'h5A; req0_valid = 1'b1;
    tick(1);
    req0_valid = 1'b0;
    n = 0;
    while (to_cnt == bt && n < 500) begin tick(1); n++; end
    if (n >= 500) bound_fail("t4_wait_timeout");
    chk("t4_timeout_latency", to_cyc - accept_cyc, T + 3);
    chk("t4_timeout_count", to_cnt - bt, 1);
    chk("t4_no_done", done0_cnt + done1_cnt - bd, 0);
    wait_idle("t4_wait_idle");
    tx_mute = 1'b0;

    // Reset while waiting for completion
    do_reset();
    bd = done0_cnt + done1_cnt; bt = to_cnt;
    req0_data = 8'h3C; req0_valid = 1'b1;
    tick(1);
    req0_valid = 1'b0;
    tick(8);
    chk("t5_in_wait", {busy, tx_en}, 2'b10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx_q.delete();
    #3;
    chk("t5_reset_outputs", {tx_byte, tx_en, busy, owner, done, timeout, req0_ready, req1_ready}, 32'h0);
    tick(60);
    chk("t5_no_pulses", {done0_cnt + done1_cnt - bd, to_cnt - bt}, 0);
    req0_data = 8'h77; req0_valid = 1'b1;
    tick(1);
    req0_valid = 1'b0;
    wait_done(bd + 1, "t5_wait_done");
    wait_idle("t5_wait_idle");
    chk("t5_after_reset_byte", rx_at(0), 32'h77);

    // Data changes after acceptance must not reach the line
    do_reset();
    bd = done0_cnt + done1_cnt;
    req0_data = 8'h81; req0_valid = 1'b1;
    tick(1);
    req0_valid = 1'b0; req0_data = 8'hFF;
    tick(3);
    req0_data = 8'hC3;
    wait_done(bd + 1, "t6_wait_done");
    wait_idle("t6_wait_idle");
    chk("t6_held_byte", rx_at(0), 32'h81);
    chk("t6_rx_count", rx_q.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
